robs_control: RTL and testbench

- Control unit for the signed Robertson's multiplier datapath. It sequences the 15-bit control word `c` that drives the datapath.
- It samples the datapath status flags `zr` (R low bit is zero) and `zq` (iteration counter's low 3 bits are zero), and runs one complete signed multiply per `start` pulse.
- It sits directly upstream of the datapath. Its `c` output connects bit-for-bit to the datapath's `c` input.

---
 rtl/robs_control.sv | 133 +++++++++++++
 tb/tb_robs_control.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/robs_control.sv
// Moore control unit for the signed Robertson multiplier datapath: sequences the
// load, add/subtract, shift and store steps of one multiply through control word c.
module robs_control #(
    parameter int WIDTH = 8,
    parameter int ITW   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        zr,
    input  logic        zq,
    output logic [14:0] c,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LOAD  = 4'd1;
    localparam logic [3:0] S_INIT  = 4'd2;
    localparam logic [3:0] S_TEST  = 4'd3;
    localparam logic [3:0] S_ADD   = 4'd4;
    localparam logic [3:0] S_ADDWB = 4'd5;
    localparam logic [3:0] S_SHLD  = 4'd6;
    localparam logic [3:0] S_SHWB  = 4'd7;
    localparam logic [3:0] S_CHK   = 4'd8;
    localparam logic [3:0] S_STORE = 4'd9;
    localparam logic [3:0] S_DONE  = 4'd10;

    // The last iteration handles the multiplier's sign bit and must subtract Y.
    localparam logic [ITW-1:0] IDX_SIGN = ITW'(WIDTH - 1);
    localparam logic [ITW-1:0] IDX_END  = ITW'(WIDTH);

    logic [3:0]     state;
    logic [3:0]     state_nx;
    logic [ITW-1:0] idx;
    logic           alu_add;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (state == S_LOAD) begin
            idx <= '0;
        end else if (state == S_SHWB) begin
            idx <= idx + ITW'(1);
        end
    end

    // Sticky cross-check between the datapath counter and our own iteration count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (state == S_CHK && (zq != (idx == IDX_END))) begin
            err <= 1'b1;
        end
    end

    // NOTE: assigning a default before the case keeps this block latch-free and sends illegal codes to IDLE.
    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:  state_nx = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_nx = S_INIT;
            S_INIT:  state_nx = S_TEST;
            S_TEST:  state_nx = zr ? S_SHLD : S_ADD;
            S_ADD:   state_nx = S_ADDWB;
            S_ADDWB: state_nx = S_SHLD;
            S_SHLD:  state_nx = S_SHWB;
            S_SHWB:  state_nx = S_CHK;
            S_CHK:   state_nx = zq ? S_STORE : S_TEST;
            S_STORE: state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_LOAD : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign alu_add = (idx != IDX_SIGN);

    always_comb begin
        c = '0;
        case (state)
            S_LOAD: begin
                c[0] = 1'b1;
                c[1] = 1'b1;
                c[2] = 1'b1;
                c[3] = 1'b1;
            end
            S_INIT: begin
                c[8] = 1'b1;
                c[9] = 1'b1;
            end
            S_ADD: begin
                c[10] = alu_add;
            end
            S_ADDWB: begin
                c[8]   = 1'b1;
                c[5:4] = 2'b10;
                c[10]  = alu_add;
            end
            S_SHLD: begin
                c[11] = 1'b1;
                c[12] = 1'b1;
            end
            S_SHWB: begin
                c[8]   = 1'b1;
                c[9]   = 1'b1;
                c[12]  = 1'b1;
                c[5:4] = 2'b01;
                c[6]   = 1'b1;
                c[13]  = 1'b1;
            end
            S_STORE: begin
                c[14] = 1'b1;
                c[3]  = 1'b1;
                c[7]  = 1'b1;
            end
            default: c = '0;
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_robs_control.sv
// Bench for robs_control: a behavioural Robertson datapath closes the loop on zr/zq,
// and a step-list model of the multiply predicts c/busy/done/err on every cycle.
module tb_robs_control;

    localparam int WIDTH = 8;
    localparam int ITW   = 4;

    typedef enum logic [3:0] {
        T_IDLE, T_LOAD, T_INIT, T_TEST, T_ADD, T_ADDWB,
        T_SHLD, T_SHWB, T_CHK, T_STORE, T_DONE
    } tag_e;

    typedef struct packed {
        tag_e           tag;
        logic [14:0]    c;
        logic [ITW-1:0] idx;
    } step_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        zr    = 1'b0;
    logic        zq    = 1'b0;
    logic [14:0] c;
    logic        busy;
    logic        done;
    logic        err;

    robs_control #(.WIDTH(WIDTH), .ITW(ITW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .zr    (zr),
        .zq    (zq),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural datapath driven by c; A/R-high carry one guard bit so the partial sums never overflow.
    logic [WIDTH-1:0]   mult  = '0;
    logic [WIDTH-1:0]   mcand = '0;
    logic [WIDTH-1:0]   dy    = '0;
    logic [WIDTH-1:0]   dx    = '0;
    logic [WIDTH-1:0]   drl   = '0;
    logic [WIDTH:0]     da    = '0;
    logic [WIDTH:0]     drh   = '0;
    logic [WIDTH:0]     dalu  = '0;
    logic [2*WIDTH:0]   ds    = '0;
    logic [ITW-1:0]     dq    = '0;
    logic [WIDTH:0]     ysx;
    logic               dp_zr;
    logic               dp_zq;

    assign ysx   = {dy[WIDTH-1], dy};
    assign dp_zr = ~drl[0];
    assign dp_zq = (dq[2:0] == 3'd0);

    always @(posedge clk) begin
        if (c[0]) dy <= mcand;
        if (c[1]) dq <= ITW'(WIDTH);
        else if (c[13]) dq <= dq - ITW'(1);
        if (c[2]) da <= '0;
        else if (c[14]) da <= drh;
        if (c[3]) dx <= c[7] ? drl : mult;
        if (c[8]) begin
            case (c[5:4])
                2'b00:   drh <= da;
                2'b01:   drh <= ds[2*WIDTH:WIDTH];
                2'b10:   drh <= dalu;
                default: drh <= drh;
            endcase
        end
        if (c[9]) drl <= c[6] ? ds[WIDTH-1:0] : dx;
        dalu <= c[10] ? drh + ysx : drh - ysx;
        if (c[11] && c[12]) ds <= $signed({drh, drl}) >>> 1;
    end

    logic start_seen = 1'b0;
    always @(posedge clk) start_seen <= start;

    // Step-list model of one multiply, built per iteration from the multiplier bits.
    step_t            sq[$];
    step_t            cur;
    logic             exp_err  = 1'b0;
    logic             err_pend = 1'b0;
    logic [WIDTH-1:0] m_mult   = '0;
    int               fault_iter = -1;
    int               addwb_cnt  = 0;
    int               addwb_sub  = 0;

    function automatic logic [14:0] bit_of(input int n);
        return 15'(1) << n;
    endfunction

    function automatic step_t mk(input tag_e t, input logic [14:0] cw, input int i);
        step_t s;
        s.tag = t;
        s.c   = cw;
        s.idx = ITW'(i);
        return s;
    endfunction

    function automatic void push_iter(input int i);
        logic [14:0] alu_mode;
        alu_mode = (i == WIDTH - 1) ? 15'd0 : bit_of(10);
        sq.push_back(mk(T_TEST, '0, i));
        if (m_mult[i % WIDTH]) begin
            sq.push_back(mk(T_ADD, alu_mode, i));
            sq.push_back(mk(T_ADDWB, bit_of(8) | bit_of(5) | alu_mode, i));
        end
        sq.push_back(mk(T_SHLD, bit_of(11) | bit_of(12), i));
        sq.push_back(mk(T_SHWB, bit_of(8) | bit_of(9) | bit_of(12) | bit_of(4) | bit_of(6) | bit_of(13), i));
        sq.push_back(mk(T_CHK, '0, i + 1));
    endfunction

    function automatic logic [15:0] ref_prod(input logic [7:0] m, input logic [7:0] y);
        int p;
        p = int'($signed(m)) * int'($signed(y));
        return p[15:0];
    endfunction

    function automatic int ref_lat(input logic [7:0] m);
        return 3 + 4 * WIDTH + 2 * $countones(m);
    endfunction

    // Compare process: advance the model, check outputs, then drive the flags for the next edge.
    initial begin
        logic zq_v;
        cur = mk(T_IDLE, '0, 0);
        forever begin
            @(negedge clk);
            if (!reset) begin
                sq.delete();
                cur      = mk(T_IDLE, '0, 0);
                exp_err  = 1'b0;
                err_pend = 1'b0;
            end else begin
                exp_err  = exp_err | err_pend;
                err_pend = 1'b0;
                if ((cur.tag == T_IDLE || cur.tag == T_DONE) && start_seen) begin
                    m_mult = mult;
                    sq.delete();
                    sq.push_back(mk(T_LOAD, bit_of(0) | bit_of(1) | bit_of(2) | bit_of(3), 0));
                    sq.push_back(mk(T_INIT, bit_of(8) | bit_of(9), 0));
                    push_iter(0);
                end
                if (sq.size() > 0) cur = sq.pop_front();
                else if (cur.tag == T_STORE || cur.tag == T_DONE) cur = mk(T_DONE, '0, 0);
                else cur = mk(T_IDLE, '0, 0);
            end
            check("c", c, cur.c);
            check("busy", busy, (cur.tag != T_IDLE && cur.tag != T_DONE));
            check("done", done, (cur.tag == T_DONE));
            check("err", err, exp_err);
            if (c[8] && c[5:4] == 2'b10) begin
                addwb_cnt++;
                if (!c[10]) addwb_sub++;
            end
            zr = (cur.tag == T_TEST) ? dp_zr : 1'($urandom);
            if (cur.tag == T_CHK) begin
                zq_v = (int'(cur.idx) == fault_iter) ? 1'b1 : dp_zq;
                zq   = zq_v;
                if (zq_v != (int'(cur.idx) == WIDTH)) err_pend = 1'b1;
                if (zq_v) sq.push_back(mk(T_STORE, bit_of(14) | bit_of(3) | bit_of(7), 0));
                else push_iter(int'(cur.idx));
            end else begin
                zq = 1'($urandom);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that shows done.
    task automatic do_mult(input logic [7:0] m, input logic [7:0] y, input bit repulse,
                           input int exp_lat, input bit chk_prod, input logic [15:0] exp_prod,
                           input string name);
        int lat;
        lat       = 0;
        mult      = m;
        mcand     = y;
        addwb_cnt = 0;
        addwb_sub = 0;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (repulse) start = (lat == 10);
            if (done) break;
        end
        start = 1'b0;
        check({name, " latency"}, lat, exp_lat);
        if (chk_prod) check({name, " product"}, {da[WIDTH-1:0], dx}, exp_prod);
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] y;
        bit         rp;
        int         gap;
        logic       found;

        repeat (3) @(negedge clk);
        #1;
        check("reset c", c, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle busy", busy, 0);

        do_mult(8'h03, 8'hFE, 1'b0, 39, 1'b1, 16'hFFFA, "3x-2");
        do_mult(8'h80, 8'h80, 1'b0, 37, 1'b1, 16'h4000, "-128x-128");
        check("sign-bit add steps", addwb_cnt, 1);
        check("sign-bit subtracts", addwb_sub, 1);
        do_mult(8'h00, 8'($urandom), 1'b0, 35, 1'b1, 16'h0000, "zero");
        do_mult(8'hFF, 8'h05, 1'b0, 51, 1'b1, 16'hFFFB, "all ones");

        // Mid-run start pulse, then an immediate back-to-back multiply from DONE.
        do_mult(8'h5A, 8'hC3, 1'b1, ref_lat(8'h5A), 1'b1, ref_prod(8'h5A, 8'hC3), "repulse");
        do_mult(8'h7F, 8'h81, 1'b0, ref_lat(8'h7F), 1'b1, ref_prod(8'h7F, 8'h81), "back-to-back");

        for (int k = 0; k < 24; k++) begin
            m   = 8'($urandom);
            y   = 8'($urandom);
            rp  = 1'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            do_mult(m, y, rp, ref_lat(m), 1'b1, ref_prod(m, y), "random");
        end

        // Asynchronous reset while an ADD step is in flight.
        mult  = 8'hFF;
        mcand = 8'h33;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            #1;
            found = (cur.tag == T_ADD);
        end
        check("reached ADD", found, 1);
        reset = 1'b0;
        #1;
        check("async reset c", c, 0);
        check("async reset busy", busy, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("stay idle c", c, 0);
        check("stay idle busy", busy, 0);
        check("stay idle done", done, 0);
        check("stay idle err", err, 0);

        // zq forced high in CHK after the third iteration.
        @(posedge clk);
        #1;
        fault_iter = 3;
        do_mult(8'h07, 8'h11, 1'b0, 21, 1'b0, 16'h0000, "zq fault");
        check("fault err", err, 1);
        fault_iter = -1;
        do_mult(8'h11, 8'h22, 1'b0, 39, 1'b1, ref_prod(8'h11, 8'h22), "after fault");
        check("err sticky", err, 1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("err cleared", err, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
